// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_seq
//  Description : Multi-cycle control sequencer for the 8-bit core. Fetches
//                9-bit instructions, drives the ALU opcode and register-file
//                controls, resolves pos/beq branches through the target LUT,
//                and runs lw/sw handshakes with data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq #(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  output logic [2:0]      rf_ra,
  output logic [2:0]      rf_rb,
  input  logic [7:0]      rf_rdb,
  output logic            rf_we,
  output logic [2:0]      rf_wa,
  output logic [7:0]      rf_wdata,
  output logic [2:0]      alu_op,
  input  logic [7:0]      alu_rslt,
  input  logic            alu_taken,
  output logic [2:0]      lut_idx,
  input  logic [PC_W-1:0] br_target,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  output logic [7:0]      dmem_wdata,
  input  logic            dmem_ack,
  input  logic [7:0]      dmem_rdata,
  output logic            busy,
  output logic            done
);

  // End-of-program compare is done one bit wider than pc so that
  // PROG_LEN = 2**PC_W is reachable before the counter wraps.
  localparam logic [PC_W:0] c_PROG_END = (PC_W+1)'(PROG_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [8:0]      r_ir;
  logic [7:0]      r_dmem_addr;
  logic [7:0]      r_dmem_wdata;
  logic            w_mem_latch;

  logic [PC_W:0]   w_pc_inc;
  logic            w_at_end;
  logic [2:0]      w_op;
  logic            w_is_mem;
  logic            w_is_br;

  assign w_pc_inc = {1'b0, r_pc} + (PC_W+1)'(1);
  assign w_at_end = (w_pc_inc == c_PROG_END);
  assign w_op     = r_ir[8:6];
  assign w_is_mem = w_op[2] & w_op[1];
  assign w_is_br  = (w_op == 3'b011) || (w_op == 3'b101);

  // Next-state, next-pc and per-cycle strobes for the sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_mem_latch = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = 8'h00;
    alu_op      = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
        end
      end
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        alu_op = w_op;
        if (w_is_mem) begin
          w_mem_latch = 1'b1;
          w_state_nxt = S_MEM;
        end else if (w_is_br && alu_taken) begin
          // A taken branch never ends the program.
          w_pc_nxt    = br_target;
          w_state_nxt = S_FETCH;
        end else begin
          if (!w_is_br) begin
            rf_we    = 1'b1;
            rf_wdata = alu_rslt;
          end
          w_pc_nxt    = w_pc_inc[PC_W-1:0];
          w_state_nxt = w_at_end ? S_HALT : S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          // ir[6] clear means load: write back the returned data now.
          if (!r_ir[6]) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          w_pc_nxt    = w_pc_inc[PC_W-1:0];
          w_state_nxt = w_at_end ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Instruction register and memory-request operand capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir         <= 9'h000;
      r_dmem_addr  <= 8'h00;
      r_dmem_wdata <= 8'h00;
    end else begin
      if (r_state == S_DECODE) begin
        r_ir <= imem_data;
      end
      if (w_mem_latch) begin
        r_dmem_addr  <= rf_rdb;
        r_dmem_wdata <= alu_rslt;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign rf_ra      = r_ir[5:3];
  assign rf_rb      = r_ir[2:0];
  assign rf_wa      = r_ir[5:3];
  assign lut_idx    = r_ir[2:0];
  // Request is purely a function of state so reset removes it at once.
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = dmem_req & r_ir[6];
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_EXEC)  || (r_state == S_MEM);
  assign done       = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_seq
//  Description : Directed testbench for ctrl_seq with behavioural ROM,
//                register file, ALU and branch-target environment.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [2:0] rf_ra, rf_rb, rf_wa, alu_op, lut_idx;
  logic [7:0] rf_rdb, rf_wdata, alu_rslt, dmem_addr, dmem_wdata, dmem_rdata;
  logic       rf_we, alu_taken, dmem_req, dmem_we, dmem_ack, busy, done;
  logic [7:0] br_target;

  logic [8:0] rom [256];
  logic [7:0] R [8];
  logic       pl_en;
  logic [2:0] pl_a;
  logic [7:0] pl_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_seq #(.PC_W(8), .PROG_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rdb(rf_rdb),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_rslt(alu_rslt), .alu_taken(alu_taken),
    .lut_idx(lut_idx), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .busy(busy), .done(done)
  );

  // Synchronous instruction ROM: data one cycle after the address.
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Register file: bench preload port or sequencer write-back.
  always @(posedge clk) begin
    if (pl_en) R[pl_a] <= pl_d;
    else if (rf_we) R[rf_wa] <= rf_wdata;
  end

  assign rf_rdb    = R[rf_rb];
  assign br_target = 8'h20;

  // Behavioural ALU; lw/sw pass R[A] through for store data.
  always_comb begin
    alu_rslt  = R[rf_ra];
    alu_taken = 1'b0;
    case (alu_op)
      3'b001: alu_rslt  = R[rf_ra] >> 1;
      3'b010: alu_rslt  = R[rf_ra] + R[rf_rb];
      3'b011: alu_taken = (R[rf_ra] != 8'h00);
      3'b100: alu_rslt  = R[rf_ra] ^ R[rf_rb];
      3'b101: alu_taken = (R[rf_ra] == 8'h00);
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    logic [8:0] instr;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic       exp_we;
    logic [7:0] exp_wdata;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{9'b010_001_010, 8'h05, 8'h07, 1'b1, 8'h0C, 8'h01}; // add
    vecs[1] = '{9'b010_001_010, 8'hC8, 8'h64, 1'b1, 8'h2C, 8'h01}; // add wraps
    vecs[2] = '{9'b001_001_010, 8'h81, 8'h00, 1'b1, 8'h40, 8'h01}; // shr
    vecs[3] = '{9'b100_001_010, 8'hF0, 8'h3C, 1'b1, 8'hCC, 8'h01}; // xor
    vecs[4] = '{9'b000_011_010, 8'h5A, 8'h00, 1'b1, 8'h5A, 8'h01}; // ld
    vecs[5] = '{9'b101_011_100, 8'h00, 8'h00, 1'b0, 8'h00, 8'h20}; // beq taken
    vecs[6] = '{9'b101_011_100, 8'h01, 8'h00, 1'b0, 8'h00, 8'h01}; // beq not
    vecs[7] = '{9'b011_011_100, 8'h80, 8'h00, 1'b0, 8'h00, 8'h20}; // pos taken
    vecs[8] = '{9'b011_011_100, 8'h00, 8'h00, 1'b0, 8'h00, 8'h01}; // pos not

    for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    reset_n = 1'b0; start = 1'b1; pl_en = 1'b0; pl_a = 3'd0; pl_d = 8'h00;
    dmem_ack = 1'b0; dmem_rdata = 8'h00;

    // Reset values, with start asserted during reset.
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_dwe", dmem_we, 0);
    chk("rst_pc", imem_addr, 0);
    chk("rst_aluop", alu_op, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_daddr", dmem_addr, 0);
    chk("rst_dwdata", dmem_wdata, 0);
    start = 1'b0;
    reset_n = 1'b1;
    step(); step();
    chk("idle_after_rst", busy, 0);

    // ALU and branch vectors, each a single instruction at pc 0.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      preload(vecs[i].instr[2:0], vecs[i].b_val);
      preload(vecs[i].instr[5:3], vecs[i].a_val);
      rom[0] = vecs[i].instr;
      kick();
      chk($sformatf("v%0d_fetch_pc", i), imem_addr, 0);
      chk($sformatf("v%0d_fetch_we", i), rf_we, 0);
      step();
      chk($sformatf("v%0d_dec_we", i), rf_we, 0);
      step();
      chk($sformatf("v%0d_aluop", i), alu_op, vecs[i].instr[8:6]);
      chk($sformatf("v%0d_we", i), rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_wa", i), rf_wa, vecs[i].instr[5:3]);
        chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
      end
      step();
      chk($sformatf("v%0d_pc", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d_busy", i), busy, 1);
    end

    // lw with ack three cycles late; a stray ack in EXEC must be ignored.
    do_reset();
    preload(3'd2, 8'h10);
    rom[0] = 9'b110_001_010;
    kick();
    step();
    step();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("lw_req%0d", k), dmem_req, 1);
      chk($sformatf("lw_addr%0d", k), dmem_addr, 8'h10);
      chk($sformatf("lw_we%0d", k), dmem_we, 0);
      chk($sformatf("lw_rfwe%0d", k), rf_we, 0);
      step();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 8'hAB;
    #1;
    chk("lw_req_ack", dmem_req, 1);
    chk("lw_rf_we", rf_we, 1);
    chk("lw_rf_wa", rf_wa, 1);
    chk("lw_rf_wdata", rf_wdata, 8'hAB);
    step();
    dmem_ack = 1'b0;
    #1;
    chk("lw_req_drop", dmem_req, 0);
    chk("lw_pc", imem_addr, 1);
    chk("lw_R1", R[1], 8'hAB);

    // sw, then a second sw cut short by reset.
    do_reset();
    preload(3'd1, 8'h55);
    preload(3'd2, 8'h09);
    rom[0] = 9'b111_001_010;
    rom[1] = 9'b111_001_010;
    kick();
    step();
    step();
    step();
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_addr", dmem_addr, 8'h09);
    chk("sw_wdata", dmem_wdata, 8'h55);
    dmem_ack = 1'b1;
    #1;
    chk("sw_no_rfwe", rf_we, 0);
    step();
    dmem_ack = 1'b0;
    chk("sw_pc", imem_addr, 1);
    step();
    step();
    step();
    chk("sw2_req", dmem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("sw2_rst_req", dmem_req, 0);
    chk("sw2_rst_busy", busy, 0);
    chk("sw2_rst_pc", imem_addr, 0);
    chk("sw2_rst_rfwe", rf_we, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("sw2_idle", busy, 0);

    // End of program at PROG_LEN = 4, start ignored while busy.
    do_reset();
    preload(3'd1, 8'h01);
    preload(3'd2, 8'h01);
    for (int i = 0; i < 4; i++) rom[i] = 9'b010_001_010;
    kick();
    step();
    step();
    step();
    chk("end_pc1", imem_addr, 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("end_pc2_busy_start", imem_addr, 2);
    step(); step(); step();
    chk("end_pc3", imem_addr, 3);
    step(); step();
    chk("end_exec_busy", busy, 1);
    chk("end_exec_done", done, 0);
    step();
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("halt_pc", imem_addr, 4);
    chk("halt_R1", R[1], 8'h05);
    step(); step();
    chk("halt_hold_done", done, 1);
    chk("halt_hold_pc", imem_addr, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    chk("restart_pc", imem_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
